spi_arbiter: RTL

- Shares one spi engine between two requesters: requester 0 is the CPU-side peripheral register path, requester 1 is an autonomous master such as a display refresher.
- Owns the spi start/busy handshake, latches per-transfer configuration at grant, and returns received data with a one-cycle done pulse.
- Sits between the peripheral register decode and the spi instance, on raw_clk.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI arbiter: FSM state encoding, the width of
// a requester index and the default start-acknowledge timeout.
package spi_pkg;

    // Arbiter FSM states; values are fixed so waveforms and debug dumps
    // read the same across tools.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Two requesters, so a single bit names one of them.
    localparam int REQ_IDX_W = 1;

    // Cycles to wait for spi_busy after raising spi_start before giving up.
    localparam int DEFAULT_START_TIMEOUT = 15;

endpackage

// File: rtl/spi_arbiter.sv
// Two-requester round-robin arbiter in front of a single SPI engine.
// Requester 0 is the CPU register path, requester 1 an autonomous master.
// The winner's transfer configuration is frozen at grant, the start/busy
// handshake is supervised with a timeout, and the received word is handed
// back with a one-cycle done pulse. Every output comes straight from a flop.
module spi_arbiter
    import spi_pkg::*;
#(
    parameter int START_TIMEOUT = DEFAULT_START_TIMEOUT
) (
    input  logic        raw_clk,
    input  logic        reset_n,
    input  logic [1:0]  req,
    input  logic [15:0] tx_data_0,
    input  logic [15:0] tx_data_1,
    input  logic [1:0]  width_16,
    input  logic [3:0]  divisor_0,
    input  logic [3:0]  divisor_1,
    output logic [1:0]  grant,
    output logic [1:0]  done,
    output logic        timeout,
    output logic [15:0] rx_data,
    output logic        spi_start,
    output logic [15:0] spi_data_tx,
    output logic        spi_width_16,
    output logic [3:0]  spi_divisor,
    input  logic        spi_busy,
    input  logic [15:0] spi_data_rx
);

    // Last counter value before the start handshake is declared dead.
    localparam logic [3:0] TIMEOUT_LAST = 4'(START_TIMEOUT - 1);

    state_t                 state, state_next;
    logic [REQ_IDX_W-1:0]   last, last_next;
    logic [REQ_IDX_W-1:0]   winner;
    logic [3:0]             counter, counter_next;
    logic [1:0]             grant_next;
    logic [1:0]             done_next;
    logic                   timeout_next;
    logic [15:0]            rx_data_next;
    logic                   spi_start_next;
    logic [15:0]            spi_data_tx_next;
    logic                   spi_width_16_next;
    logic [3:0]             spi_divisor_next;

    // A lone requester always wins; on contention the one that did not go
    // last gets the engine, so neither side can starve the other.
    function automatic logic [REQ_IDX_W-1:0] pick_winner(input logic [1:0] r,
                                                         input logic [REQ_IDX_W-1:0] l);
        logic [REQ_IDX_W-1:0] w;
        case (r)
            2'b01:   w = 1'b0;
            2'b10:   w = 1'b1;
            default: w = ~l;
        endcase
        return w;
    endfunction

    // Next-state and next-output logic; registers hold their value unless a
    // state below says otherwise, and the pulses default low.
    always_comb begin
        state_next        = state;
        last_next         = last;
        counter_next      = counter;
        grant_next        = grant;
        done_next         = 2'b00;
        timeout_next      = 1'b0;
        rx_data_next      = rx_data;
        spi_start_next    = spi_start;
        spi_data_tx_next  = spi_data_tx;
        spi_width_16_next = spi_width_16;
        spi_divisor_next  = spi_divisor;
        winner            = pick_winner(req, last);

        case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    grant_next        = (winner == 1'b1) ? 2'b10 : 2'b01;
                    last_next         = winner;
                    spi_data_tx_next  = (winner == 1'b1) ? tx_data_1 : tx_data_0;
                    spi_width_16_next = width_16[winner];
                    spi_divisor_next  = (winner == 1'b1) ? divisor_1 : divisor_0;
                    spi_start_next    = 1'b1;
                    counter_next      = 4'd0;
                    state_next        = START;
                end
            end
            START: begin
                if (spi_busy) begin
                    spi_start_next = 1'b0;
                    state_next     = BUSY;
                end else if (counter == TIMEOUT_LAST) begin
                    spi_start_next = 1'b0;
                    timeout_next   = 1'b1;
                    grant_next     = 2'b00;
                    state_next     = IDLE;
                end else begin
                    counter_next = counter + 4'd1;
                end
            end
            BUSY: begin
                if (!spi_busy) begin
                    rx_data_next = spi_data_rx;
                    done_next    = grant;
                    state_next   = DONE;
                end
            end
            DONE: begin
                grant_next = 2'b00;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers; reset wins over any transfer in flight and
    // leaves the SPI engine to wind down by itself.
    always_ff @(posedge raw_clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            last         <= 1'b1;
            counter      <= 4'd0;
            grant        <= 2'b00;
            done         <= 2'b00;
            timeout      <= 1'b0;
            rx_data      <= 16'h0000;
            spi_start    <= 1'b0;
            spi_data_tx  <= 16'h0000;
            spi_width_16 <= 1'b0;
            spi_divisor  <= 4'h0;
        end else begin
            state        <= state_next;
            last         <= last_next;
            counter      <= counter_next;
            grant        <= grant_next;
            done         <= done_next;
            timeout      <= timeout_next;
            rx_data      <= rx_data_next;
            spi_start    <= spi_start_next;
            spi_data_tx  <= spi_data_tx_next;
            spi_width_16 <= spi_width_16_next;
            spi_divisor  <= spi_divisor_next;
        end
    end

endmodule
